mem_request_queue: RTL

//  Circular FIFO sitting directly downstream of the trace parser. Stores up to

---
 rtl/mem_request_queue_pkg.sv | 27 ++
 rtl/mem_request_queue.sv | 95 +++++++++
 2 files changed

// File: rtl/mem_request_queue_pkg.sv
// rtl/mem_request_queue_pkg.sv - shared widths, request types and age helper
package mem_request_queue_pkg;

  localparam int QUEUE_SIZE    = 16;
  localparam int ADDRESS_WIDTH = 32;
  localparam int AGE_WIDTH     = 8;
  localparam int PTR_WIDTH     = $clog2(QUEUE_SIZE);
  localparam int COUNT_WIDTH   = PTR_WIDTH + 1;

  typedef enum logic [1:0] {
    NOP          = 2'd0,
    DATA_READ    = 2'd1,
    DATA_WRITE   = 2'd2,
    OPCODE_FETCH = 2'd3
  } parsed_op_t;

  typedef struct packed {
    parsed_op_t                op;
    logic [ADDRESS_WIDTH-1:0]  address;
  } mem_request_t;

  // Saturating increment: an entry that has waited the maximum stays there.
  function automatic logic [AGE_WIDTH-1:0] age_next(input logic [AGE_WIDTH-1:0] age);
    return (&age) ? age : age + 1'b1;
  endfunction

endpackage

// File: rtl/mem_request_queue.sv
// rtl/mem_request_queue.sv - circular request FIFO with per-entry age tracking
module mem_request_queue
  import mem_request_queue_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  parsed_op_t               in_op,
  input  logic [ADDRESS_WIDTH-1:0] in_address,
  output logic                     in_ready,
  output logic                     out_valid,
  output parsed_op_t               out_op,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic [AGE_WIDTH-1:0]     out_age,
  input  logic                     out_ready,
  output logic [COUNT_WIDTH-1:0]   count,
  output logic                     full,
  output logic                     empty
);

  mem_request_t                          entries [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0][AGE_WIDTH-1:0]  ages;
  logic [PTR_WIDTH-1:0]                  head_ptr;
  logic [PTR_WIDTH-1:0]                  tail_ptr;
  logic [COUNT_WIDTH-1:0]                count_q;
  logic                                  push_en;
  logic                                  pop_en;

  // Status is derived purely from the registered count, so out_ready never
  // reaches in_ready combinationally and a pop cannot open a slot early.
  assign full     = (count_q == COUNT_WIDTH'(QUEUE_SIZE));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign in_ready = !full;

  // NOP requests carry no work for the controller and are dropped here.
  assign push_en = in_valid && !full && (in_op != NOP);
  assign pop_en  = out_ready && !empty;

  // Head presentation; idle values when nothing is resident.
  assign out_valid   = !empty;
  assign out_op      = empty ? NOP : entries[head_ptr].op;
  assign out_address = empty ? '0  : entries[head_ptr].address;
  assign out_age     = empty ? '0  : ages[head_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) tail_ptr <= tail_ptr + 1'b1;
      if (pop_en)  head_ptr <= head_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Request storage; contents are only observed while the slot is occupied.
  always_ff @(posedge clk) begin
    if (push_en) begin
      entries[tail_ptr] <= '{op: in_op, address: in_address};
    end
  end

  // Per-entry residency tracking. Push and pop can never target the same
  // slot in one cycle: that would need the queue both empty and full.
  for (genvar i = 0; i < QUEUE_SIZE; i++) begin : g_entry
    logic                 occupied;
    logic [AGE_WIDTH-1:0] age_q;

    // Start at zero on write, clear on pop, otherwise age one step per cycle.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        occupied <= 1'b0;
        age_q    <= '0;
      end else if (push_en && (tail_ptr == PTR_WIDTH'(i))) begin
        occupied <= 1'b1;
        age_q    <= '0;
      end else if (pop_en && (head_ptr == PTR_WIDTH'(i))) begin
        occupied <= 1'b0;
        age_q    <= '0;
      end else if (occupied) begin
        age_q    <= age_next(age_q);
      end
    end

    assign ages[i] = age_q;
  end

endmodule
